// File: rtl/fp_div_pkg.sv
// Shared constants and types for the iterative floating-point divider.
package fp_div_pkg;

   localparam int FP_WIDTH  = 32;
   localparam int EXP_WIDTH = 8;
   localparam int MAN_WIDTH = 23;
   localparam int EXP_BIAS  = 127;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef struct packed {
      logic                 sign;
      logic [EXP_WIDTH-1:0] exp;
      logic [MAN_WIDTH-1:0] man;
   } fp_t;

endpackage

// File: rtl/mantissa_div_iter.sv
// Restoring mantissa divider: one quotient bit per cycle for ITER_BITS cycles.
module mantissa_div_iter #(
   parameter int ITER_BITS = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] dividend,
   input  logic [23:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [24:0] quot
);

   localparam logic [4:0] LAST = 5'(ITER_BITS);
   localparam int         PAD  = 25 - ITER_BITS;

   logic [24:0] rem_p0;
   logic [24:0] quot_p0;
   logic [23:0] div_p0;
   logic [4:0]  cnt_p0;
   logic        run_p0;
   logic        ge;
   logic [24:0] diff;

   always_comb begin
      ge   = rem_p0 >= {1'b0, div_p0};
      diff = rem_p0 - {1'b0, div_p0};
   end

   assign busy = run_p0 && (cnt_p0 != LAST);
   assign done = run_p0 && (cnt_p0 == LAST);
   // Bits are shifted in LSB-first; align so the first bit lands at weight 2^0.
   assign quot = quot_p0 << PAD;

   always_ff @(posedge clk) begin
      if (rst) begin
         run_p0 <= 1'b0;
         cnt_p0 <= '0;
      end else if (start) begin
         run_p0 <= 1'b1;
         cnt_p0 <= '0;
      end else if (done) begin
         run_p0 <= 1'b0;
      end else if (busy) begin
         cnt_p0 <= cnt_p0 + 5'd1;
      end
   end

   // Remainder stays below 2*D, so 25 bits hold every shifted value.
   always_ff @(posedge clk) begin
      if (start) begin
         rem_p0  <= {1'b0, dividend};
         div_p0  <= divisor;
         quot_p0 <= '0;
      end else if (busy) begin
         rem_p0  <= ge ? {diff[23:0], 1'b0} : {rem_p0[23:0], 1'b0};
         quot_p0 <= {quot_p0[23:0], ge};
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative single-precision divider X/Y with valid/ready handshakes.
// Optional macro FP_DIV_ZERO_DETECT_EN: zero divisor returns signed infinity after one edge.
module fp_div_iter
   import fp_div_pkg::*;
#(
   parameter int ITER_BITS = 25
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                In_Valid,
   output logic                In_Ready,
   input  logic [FP_WIDTH-1:0] X_Input,
   input  logic [FP_WIDTH-1:0] Y_Input,
   output logic                Out_Valid,
   input  logic                Out_Ready,
   output logic [FP_WIDTH-1:0] Result
);

   state_t             state_p0, state_nxt;
   logic               sign_p0;
   logic signed [9:0]  exp_p0;
   fp_t                res_p0;
   logic               accept;
   logic               start;
   logic               mant_busy;
   logic               mant_done;
   logic [24:0]        mant_q;

   function automatic logic [30:0] normalise(input logic signed [9:0] e, input logic [24:0] q);
      logic signed [9:0] eb;
      if (q[24]) begin
         eb = e + 10'(EXP_BIAS);
         return {eb[7:0], q[23:1]};
      end
      eb = e + 10'(EXP_BIAS - 1);
      return {eb[7:0], q[22:0]};
   endfunction

   mantissa_div_iter #(.ITER_BITS(ITER_BITS)) u_mant (
      .clk      (Clk),
      .rst      (Rst),
      .start    (start),
      .dividend ({1'b1, X_Input[22:0]}),
      .divisor  ({1'b1, Y_Input[22:0]}),
      .busy     (mant_busy),
      .done     (mant_done),
      .quot     (mant_q)
   );

   assign accept    = (state_p0 == IDLE) && In_Valid;
   assign In_Ready  = (state_p0 == IDLE);
   assign Out_Valid = (state_p0 == DONE);
   assign Result    = res_p0;

`ifdef FP_DIV_ZERO_DETECT_EN
   logic y_zero;
   logic zero_p0;
   assign y_zero = (Y_Input[30:0] == 31'd0);
   always_ff @(posedge Clk) begin
      if (accept) zero_p0 <= y_zero;
   end
`endif

   always_ff @(posedge Clk) begin
      if (Rst) state_p0 <= IDLE;
      else     state_p0 <= state_nxt;
   end

   always_comb begin
      state_nxt = state_p0;
      start     = 1'b0;
      case (state_p0)
         IDLE: begin
            if (In_Valid) begin
               state_nxt = BUSY;
`ifdef FP_DIV_ZERO_DETECT_EN
               start     = !y_zero;
`else
               start     = 1'b1;
`endif
            end
         end
         // A zero-divisor accept never starts the mantissa unit, so it leaves after one cycle.
         BUSY:    if (!mant_busy) state_nxt = DONE;
         DONE:    if (Out_Ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (accept) begin
         sign_p0 <= X_Input[31] ^ Y_Input[31];
         exp_p0  <= signed'({2'b00, X_Input[30:23]}) - signed'({2'b00, Y_Input[30:23]});
      end
   end

   // Result is the only datapath register with a reset value: it is architecturally visible.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         res_p0 <= '0;
`ifdef FP_DIV_ZERO_DETECT_EN
      end else if ((state_p0 == BUSY) && zero_p0) begin
         res_p0 <= {sign_p0, 8'hFF, 23'd0};
`endif
      end else if ((state_p0 == BUSY) && mant_done) begin
         res_p0 <= {sign_p0, normalise(exp_p0, mant_q)};
      end
   end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: vector table plus handshake and reset sequences.
module tb_fp_div_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [31:0] x_in = '0, y_in = '0, result;
   logic        iv13 = 1'b0, or13 = 1'b0;
   logic        ir13, ov13;
   logic [31:0] x13 = '0, y13 = '0, r13;

   int total = 0;
   int passed = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   fp_div_iter dut (
      .Clk(clk), .Rst(rst), .In_Valid(in_valid), .In_Ready(in_ready),
      .X_Input(x_in), .Y_Input(y_in), .Out_Valid(out_valid),
      .Out_Ready(out_ready), .Result(result)
   );

   fp_div_iter #(.ITER_BITS(13)) dut13 (
      .Clk(clk), .Rst(rst), .In_Valid(iv13), .In_Ready(ir13),
      .X_Input(x13), .Y_Input(y13), .Out_Valid(ov13),
      .Out_Ready(or13), .Result(r13)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      x_in = x; y_in = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
   endtask

   task automatic release_out;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] res;
      int          lat;

      vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 26}; // 6/2
      vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26}; // 1/3 truncated
      vecs[2] = '{32'hC1000000, 32'h40000000, 32'hC0800000, 26}; // -8/2
      vecs[3] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 26}; // 1/1
      vecs[4] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 26}; // 1/2
      vecs[5] = '{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 26}; // 1/1.5
      vecs[6] = '{32'h7F000000, 32'h00800000, 32'h3E000000, 26}; // exponent wraps
`ifdef FP_DIV_ZERO_DETECT_EN
      vecs[7] = '{32'h40000000, 32'h80000000, 32'hFF800000, 1};
`else
      vecs[7] = '{32'h40000000, 32'h80000000, 32'hFF800000, 26};
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_result13", r13, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         do_div(vecs[i].x, vecs[i].y, res, lat);
         chk($sformatf("vec%0d_result", i), res, vecs[i].res);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         release_out();
      end

      // Reduced-precision instance: 1/3 with 13 quotient bits
      @(negedge clk);
      x13 = 32'h3F800000; y13 = 32'h40400000; iv13 = 1'b1;
      @(posedge clk); #1;
      iv13 = 1'b0;
      lat = 0;
      while (!ov13 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("it13_result", r13, 32'h3EAAA000);
      chk("it13_latency", 32'(lat), 32'd14);
      @(negedge clk); or13 = 1'b1;
      @(posedge clk); #1; or13 = 1'b0;
      chk("it13_in_ready", {31'd0, ir13}, 32'd1);

      // Handshake: In_Valid during BUSY ignored, backpressure holds the result
      @(negedge clk);
      x_in = 32'h40C00000; y_in = 32'h40000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      x_in = 32'h3F800000; y_in = 32'h40400000; in_valid = 1'b1;
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("hs_result", result, 32'h40400000);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("hold_result", result, 32'h40400000);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      release_out();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("no_queue_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset during the fifth iteration aborts the divide
      @(negedge clk);
      x_in = 32'h3F800000; y_in = 32'h40400000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      do_div(32'h40C00000, 32'h40000000, res, lat);
      chk("post_abort_result", res, 32'h40400000);
      chk("post_abort_latency", 32'(lat), 32'd26);
      release_out();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
